clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_prog_if.sv | 27 ++
 rtl/clk_div_odd_fix.sv | 17 +
 rtl/clk_div_prog.sv | 102 ++++++++++
 tb/tb_clk_div_prog.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, pending-ratio state type and duty-threshold helper for clk_div_prog
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int MIN_DIV     = 2;
  localparam int DEF_DIV_DEF = 6;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  // Number of phase counts the output stays high: ceil(n/2), or floor(n/2) when floor_mode is set.
  function automatic logic [31:0] duty_thresh(input logic [31:0] n, input logic floor_mode);
    duty_thresh = floor_mode ? (n >> 1) : ((n >> 1) + {31'b0, n[0]});
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - divide-ratio update handshake between a configuring master and clk_div_prog
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             cfg_valid_i;
  logic [CNT_W-1:0] cfg_div_i;
  logic             cfg_ready_o;
  logic             cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_div_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_div_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/clk_div_odd_fix.sv
// rtl/clk_div_odd_fix.sv - falling-edge copy of the duty term, extending odd-ratio high time by half a clk
module clk_div_odd_fix (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with glitch-free ratio update; CLK_DIV_ODD_DUTY_EN enables 50% duty for odd ratios
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  clk_div_prog_if.slave    cfg,
  output logic             clk_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_q;
  logic             err_q;
  pend_state_t      pend_st;
  pend_state_t      pend_nx;

  logic             ratio_ok;
  logic             accept;
  logic             reject;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] hi_ceil;
  logic             ceil_term;

  assign ratio_ok = (cfg.cfg_div_i >= CNT_W'(MIN_DIV));
  assign accept   = cfg.cfg_valid_i && ratio_ok && (pend_st == PEND_EMPTY);
  assign reject   = cfg.cfg_valid_i && !ratio_ok;
  assign wrap     = (cnt_q == div_q - CNT_W'(1));
  // A ratio loaded during a wrap cycle sees PEND_EMPTY there, so it waits for the next wrap.
  assign apply    = (pend_st == PEND_FULL) && (!en_i || wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_st <= PEND_EMPTY;
    end else begin
      pend_st <= pend_nx;
    end
  end

  always_comb begin
    pend_nx = pend_st;
    case (pend_st)
      PEND_EMPTY: if (accept) pend_nx = PEND_FULL;
      PEND_FULL:  if (apply)  pend_nx = PEND_EMPTY;
      default:    pend_nx = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEF_DIV);
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) pend_q <= cfg.cfg_div_i;
      if (apply)  div_q  <= pend_q;
      if (!en_i || wrap) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign hi_ceil   = CNT_W'(duty_thresh(32'(div_q), 1'b0));
  assign ceil_term = (cnt_q < hi_ceil);

`ifdef CLK_DIV_ODD_DUTY_EN
  logic [CNT_W-1:0] hi_floor;
  logic             floor_term;
  logic             floor_neg;

  assign hi_floor   = CNT_W'(duty_thresh(32'(div_q), 1'b1));
  assign floor_term = en_i && (cnt_q < hi_floor);

  clk_div_odd_fix u_odd_fix (
    .clk   (clk),
    .reset (reset),
    .d     (floor_term),
    .q     (floor_neg)
  );

  assign clk_o = en_i && (div_q[0] ? (floor_term || floor_neg) : ceil_term);
`else
  assign clk_o = en_i && ceil_term;
`endif

  assign tick_o          = en_i && (cnt_q == '0);
  assign cnt_o           = en_i ? cnt_q : '0;
  assign cfg.cfg_ready_o = (pend_st == PEND_EMPTY);
  assign cfg.cfg_err_o   = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed scoreboard bench for clk_div_prog
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic       clk_o;
  logic       tick_o;
  logic [7:0] cnt_o;

  int errors = 0;
  int checks = 0;

`ifdef CLK_DIV_ODD_DUTY_EN
  localparam int HL5 = 2;
`else
  localparam int HL5 = 3;
`endif

  typedef struct {
    logic       ce;
    logic       cl;
    logic       tk;
    logic [7:0] cnt;
    logic       rdy;
    logic       err;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  clk_div_prog_if #(.CNT_W(8)) cfg_if ();

  clk_div_prog #(.CNT_W(8), .DEF_DIV(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en_i),
    .cfg    (cfg_if.slave),
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .cnt_o  (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic en, input logic v, input logic [7:0] d,
                      input logic ce, input logic cl, input logic tk, input logic [7:0] ecnt,
                      input logic rdy, input logic err, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset              = rst;
    en_i               = en;
    cfg_if.cfg_valid_i = v;
    cfg_if.cfg_div_i   = d;
    e.ce  = ce;
    e.cl  = cl;
    e.tk  = tk;
    e.cnt = ecnt;
    e.rdy = rdy;
    e.err = err;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // count cycles of divide-by-n; he/hl = high counts seen early/late in each clk period
  task automatic run(input int n, input int he, input int hl, input int count,
                     input int off_k, input logic [7:0] off_d,
                     input int r0, input int r1, input int err_k, input string nm);
    for (int k = 0; k < count; k++) begin
      int j;
      j = k % n;
      step(1'b0, 1'b1, (k == off_k), (k == off_k) ? off_d : 8'd0,
           (j < he), (j < hl), (j == 0), 8'(j),
           !((k >= r0) && (k < r1)), (k == err_k), nm);
    end
  endtask

  initial begin
    exp_t       e;
    logic       s_ce, s_cl, s_tk, s_rdy, s_err;
    logic [7:0] s_cnt;
    forever begin
      @(posedge clk);
      #3;
      s_ce  = clk_o;
      s_tk  = tick_o;
      s_cnt = cnt_o;
      s_rdy = cfg_if.cfg_ready_o;
      s_err = cfg_if.cfg_err_o;
      #5;
      s_cl  = clk_o;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({s_ce, s_cl, s_tk, s_cnt, s_rdy, s_err} !== {e.ce, e.cl, e.tk, e.cnt, e.rdy, e.err}) begin
          errors++;
          $display("FAIL %s: got clk=%b/%b tick=%b cnt=%0d rdy=%b err=%b, want clk=%b/%b tick=%b cnt=%0d rdy=%b err=%b",
                   e.nm, s_ce, s_cl, s_tk, s_cnt, s_rdy, s_err, e.ce, e.cl, e.tk, e.cnt, e.rdy, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, want finish");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    en_i               = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_div_i   = 8'd0;

    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "idle");

    run(6, 3, 3, 12, -1, 8'd0, 0, 0, -1, "div6");
    run(6, 3, 3, 6,   2, 8'd4, 3, 6, -1, "div6_to4");
    run(4, 2, 2, 8,  -1, 8'd0, 0, 0, -1, "div4");
    run(4, 2, 2, 4,   1, 8'd6, 2, 4, -1, "div4_to6");
    run(6, 3, 3, 6,   5, 8'd3, 6, 6, -1, "wrap_offer");
    run(6, 3, 3, 6,  -1, 8'd0, 0, 6, -1, "div6_held");
    run(3, 2, 2, 6,  -1, 8'd0, 0, 0, -1, "div3");
    run(3, 2, 2, 3,   0, 8'd6, 1, 3, -1, "div3_to6");
    run(6, 3, 3, 6,   0, 8'd1, 0, 0,  1, "rej1");
    run(6, 3, 3, 6,   2, 8'd0, 0, 0,  3, "rej0");
    run(6, 3, 3, 6,  -1, 8'd0, 0, 0, -1, "div6_after_rej");
    run(6, 3, 3, 6,   0, 8'd5, 1, 6, -1, "div6_to5");
    run(5, 3, HL5, 10, -1, 8'd0, 0, 0, -1, "div5");
    run(5, 3, HL5, 2,  -1, 8'd0, 0, 0, -1, "div5_part");

    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "en_off");
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "en_off_hold");
    step(1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "off_offer");
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "off_pend");
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "off_applied");
    run(4, 2, 2, 8,  -1, 8'd0, 0, 0, -1, "div4_en");

    run(4, 2, 2, 3,   0, 8'd8, 1, 3, -1, "div4_pend8");
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, "reset_mid");
    run(6, 3, 3, 12, -1, 8'd0, 0, 0, -1, "after_reset");

    @(posedge clk);
    #9;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
